// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the serial line, control inputs and byte-level outputs
// of the UART receiver.
//   en        receiver enable (low aborts and holds the receiver idle)
//   baud      clocks per bit period (values below 4 act as 4)
//   rx        asynchronous serial input, idle high
//   data      last received byte
//   valid     one-cycle pulse when data is updated with a good frame
//   frame_err one-cycle pulse when the stop bit samples low
//   busy      high whenever the receiver is not idle
// The master modport is the side that drives the line and the controls.
// The slave modport is the receiver itself.
interface uart_rx_if #(
    parameter int DATA_BITS = 8,
    parameter int BAUD_W    = 20
);
    logic                 en;
    logic [BAUD_W-1:0]    baud;
    logic                 rx;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output en, baud, rx,
        input  data, valid, frame_err, busy
    );

    modport slave (
        input  en, baud, rx,
        output data, valid, frame_err, busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with a run-time divisor in clocks per bit.
//   clk   system clock
//   rstn  asynchronous active-low reset
//   bus   uart_rx_if.slave: en, baud, rx in; data, valid, frame_err, busy out
// The rx pin is synchronized, a falling edge starts a frame, and the line is
// sampled near the middle of each bit. A good stop bit pulses valid. A low stop
// bit pulses frame_err and parks the receiver until the line returns high.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int BAUD_W    = 20
) (
    input  logic     clk,
    input  logic     rstn,
    uart_rx_if.slave bus
);
    localparam int BCW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_nxt;
    logic [1:0]           sync;
    logic                 rxs;
    logic [BAUD_W-1:0]    b_eff;
    logic [BAUD_W-1:0]    b_lat;
    logic [BAUD_W-1:0]    cnt;
    logic [BAUD_W-1:0]    target;
    logic                 tick;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;

    // Two-flop synchronizer. It resets to 1 so that reset never looks like a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= 2'b11;
        end else begin
            // NOTE: flops use non-blocking assignments so every register
            // sees the values from before the edge.
            sync <= {sync[0], bus.rx};
        end
    end
    assign rxs = sync[1];

    assign b_eff = (bus.baud < BAUD_W'(4)) ? BAUD_W'(4) : bus.baud;

    // The counter restarts at 1 on the detect edge and on each sample edge.
    // It therefore equals the number of cycles since that edge. START waits half a
    // period and every later sample waits a full period.
    assign target = (state == S_START) ? (b_lat >> 1) : b_lat;
    assign tick   = (cnt == target);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: the default assignment first means that every path assigns
        // state_nxt, so no latch is inferred.
        state_nxt = state;
        if (!bus.en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (!rxs) state_nxt = S_START;
                S_START: if (tick) state_nxt = rxs ? S_IDLE : S_DATA;
                S_DATA:  if (tick && bit_cnt == BCW'(DATA_BITS - 1)) state_nxt = S_STOP;
                S_STOP:  if (tick) state_nxt = rxs ? S_IDLE : S_BREAK;
                S_BREAK: if (rxs)  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            b_lat   <= BAUD_W'(4);
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            // When en is low, every register holds its value. The FSM goes to
            // IDLE, so the frame in progress is simply dropped.
            if (bus.en) begin
                case (state)
                    S_IDLE: begin
                        if (!rxs) begin
                            b_lat   <= b_eff;
                            cnt     <= BAUD_W'(1);
                            bit_cnt <= '0;
                        end
                    end
                    S_START: begin
                        cnt <= tick ? BAUD_W'(1) : cnt + BAUD_W'(1);
                    end
                    S_DATA: begin
                        cnt <= tick ? BAUD_W'(1) : cnt + BAUD_W'(1);
                        if (tick) begin
                            shift   <= {rxs, shift[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                    S_STOP: begin
                        cnt <= tick ? BAUD_W'(1) : cnt + BAUD_W'(1);
                        if (tick) begin
                            data_q  <= shift;
                            valid_q <= rxs;
                            ferr_q  <= !rxs;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. The stimulus drives complete
// serial frames. For each frame it pushes the byte, and whether a framing error
// is expected, into a scoreboard queue. A monitor pops one entry on every valid
// or frame_err pulse and compares the entry with the pulse.
module tb_uart_rx;
    typedef struct packed {
        logic       err;
        logic [7:0] d;
    } exp_t;

    logic clk;
    logic rstn;
    uart_rx_if #(.DATA_BITS(8), .BAUD_W(20)) bus ();

    uart_rx #(.DATA_BITS(8), .BAUD_W(20)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    exp_t       sb[$];
    logic [7:0] last_data;
    int         vectors = 0;
    int         errors  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hold the line at v for n clock periods. Changes are made on the falling edge.
    task automatic drive_bit(input logic v, input int n);
        @(negedge clk);
        bus.rx = v;
        repeat (n - 1) @(negedge clk);
    endtask

    // Send one frame at bpc clocks per bit. If abort_bit >= 0, en is dropped
    // halfway through that data bit.
    task automatic send_frame(input logic [7:0] d, input int bpc, input logic stop_bit,
                              input int abort_bit);
        drive_bit(1'b0, bpc);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                drive_bit(d[i], bpc / 2);
                bus.en = 1'b0;
                drive_bit(d[i], bpc - bpc / 2);
            end else begin
                drive_bit(d[i], bpc);
            end
        end
        drive_bit(stop_bit, bpc);
    endtask

    // Reference model: the receiver should return exactly the byte that was
    // sent. It should flag an error exactly when the stop bit was low.
    task automatic send_exp(input logic [7:0] d, input int bpc, input logic stop_bit);
        exp_t e;
        e.err = !stop_bit;
        e.d   = d;
        sb.push_back(e);
        send_frame(d, bpc, stop_bit, -1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: each output pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        last_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rstn && (bus.valid || bus.frame_err)) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {30'd0, bus.valid, bus.frame_err}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", {30'd0, bus.valid, bus.frame_err},
                          e.err ? 32'd1 : 32'd2);
                    check("rx_data", {24'd0, bus.data}, {24'd0, e.d});
                    last_data = e.d;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d entries pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bpc;
        logic [7:0] d;
        logic stop_bit;

        bus.en   = 1'b1;
        bus.baud = 20'd20;
        bus.rx   = 1'b1;
        rstn     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data",  {24'd0, bus.data}, 32'd0);
        check("reset_valid", {31'd0, bus.valid}, 32'd0);
        check("reset_ferr",  {31'd0, bus.frame_err}, 32'd0);
        check("reset_busy",  {31'd0, bus.busy}, 32'd0);
        rstn = 1'b1;
        idle(5);

        // Good byte.
        fork
            send_exp(8'hA5, 20, 1'b1);
            begin
                repeat (60) @(negedge clk);
                check("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
            end
        join
        idle(5);
        check("busy_after_frame", {31'd0, bus.busy}, 32'd0);

        // Back-to-back bytes with no idle gap.
        send_exp(8'h00, 20, 1'b1);
        send_exp(8'hFF, 20, 1'b1);
        send_exp(8'h3C, 20, 1'b1);
        idle(10);

        // Glitch rejection. The start sample lands after the line is high again.
        drive_bit(1'b0, 5);
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_during_glitch", {31'd0, bus.busy}, 32'd1);
        repeat (15) @(negedge clk);
        check("busy_after_glitch", {31'd0, bus.busy}, 32'd0);
        idle(20);

        // Framing error, then the line is held low (BREAK must not retrigger).
        send_exp(8'h55, 20, 1'b0);
        repeat (40) @(negedge clk);
        check("busy_in_break", {31'd0, bus.busy}, 32'd1);
        idle(5);
        check("busy_after_break", {31'd0, bus.busy}, 32'd0);
        idle(250);

        // Abort with en during bit 3. Nothing is expected, and data holds.
        send_frame(8'h81, 20, 1'b1, 3);
        idle(30);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_data_held", {24'd0, bus.data}, {24'd0, last_data});
        bus.en = 1'b1;
        idle(5);
        send_exp(8'h81, 20, 1'b1);
        idle(10);

        // Reset in the middle of a frame.
        drive_bit(1'b0, 20);
        drive_bit(1'b1, 20);
        repeat (10) @(negedge clk);
        check("busy_before_reset", {31'd0, bus.busy}, 32'd1);
        rstn = 1'b0;
        #1;
        check("midrst_data",  {24'd0, bus.data}, 32'd0);
        check("midrst_valid", {31'd0, bus.valid}, 32'd0);
        check("midrst_ferr",  {31'd0, bus.frame_err}, 32'd0);
        check("midrst_busy",  {31'd0, bus.busy}, 32'd0);
        last_data = 8'h00;
        idle(5);
        rstn = 1'b1;
        idle(5);
        check("busy_after_reset", {31'd0, bus.busy}, 32'd0);

        // Clamp: a divisor of 2 behaves as 4.
        bus.baud = 20'd2;
        send_exp(8'h6E, 4, 1'b1);
        idle(10);

        // Random frames: random divisor, byte, stop bit and gap.
        for (int n = 0; n < 24; n++) begin
            bpc = $urandom_range(4, 24);
            bus.baud = (bpc == 4) ? 20'($urandom_range(0, 4)) : 20'(bpc);
            d = 8'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 5) != 0);
            send_exp(d, bpc, stop_bit);
            if (!stop_bit) repeat ($urandom_range(0, 30)) @(negedge clk);
            if (!stop_bit || $urandom_range(0, 1) == 1) idle($urandom_range(0, 5));
        end
        idle(60);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the consuming end of the serial link timed by the team's baud counter. It deserializes 8N1 frames from an asynchronous `rx` line using a run-time `baud` divisor, given in clocks per bit and shared with the transmit side. Each good byte is presented with a one-cycle `valid` pulse. A bad stop bit produces a one-cycle `frame_err` pulse. The block sits between the pad-side `rx` input and the byte-level consumer logic.

## Interface
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `BAUD_W`, default 20: width of the `baud` divisor.
- `clk` in 1: system clock.
- `rstn` in 1: asynchronous active-low reset.
- `en` in 1: receiver enable. Low aborts any frame and holds the block in IDLE.
- `baud` in BAUD_W: clocks per bit period. Values below 4 are treated as 4.
- `rx` in 1: serial input, asynchronous, idle high.
- `data` out DATA_BITS: last received byte. Holds until the next frame completes.
- `valid` out 1: one-cycle pulse when `data` is updated with a good frame.
- `frame_err` out 1: one-cycle pulse when the stop bit samples low.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Input sync:** `rx` passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value `rxs`.
- **Divisor latch:** the effective divisor B is `max(baud,4)`. It is latched when the start bit is detected. Changes to `baud` mid-frame have no effect.
- **States:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** if `en` and `rxs`==0, latch B, clear the bit counter, and go to START.
  - **START:** wait floor(B/2) cycles, then sample `rxs`. If 0, go to DATA. If 1, the start was a glitch: return to IDLE with no pulse.
  - **DATA:** sample every B cycles. Shift each sample into bit `DATA_BITS-1` of the shift register, shifting right. After `DATA_BITS` samples, go to STOP.
  - **STOP:** sample after B cycles. If 1, load `data` from the shift register, pulse `valid`, and go to IDLE. If 0, load `data` anyway, pulse `frame_err`, and go to BREAK.
  - **BREAK:** wait until `rxs`==1, then go to IDLE. This prevents a held-low line from retriggering.
- **Enable:** `en`=0 in any state forces IDLE on the next edge. No `valid` or `frame_err` is issued, and `data` is unchanged.
- **Counters:** the bit-period counter is BAUD_W wide and never wraps within a frame. The bit counter is ceil(log2(DATA_BITS+1)) bits.
- **Reset:** `rstn` low, at any time including mid-frame, returns the block to IDLE. Reset values: `data`=0, `valid`=0, `frame_err`=0, `busy`=0, synchronizer=1, shift register=0.

## Timing
- **Start reference:** T0 is the first edge at which IDLE sees `rxs`==0. This is 2–3 cycles after the pin falls.
- **Sample points:**
  - Start sample at T0+floor(B/2).
  - Data bit i (i=0..DATA_BITS-1) sampled at T0+floor(B/2)+(i+1)·B.
  - Stop sample at T0+floor(B/2)+(DATA_BITS+1)·B.
- **Outputs:** `valid`/`frame_err` are registered and high for exactly the one cycle after the stop sample. `data` changes in that same cycle. `busy` is high from T0+1 until the cycle IDLE is re-entered.
- **Back-to-back frames:** a new start bit arriving during STOP's final cycle or later is accepted. IDLE re-detects it on the first cycle back in IDLE, with no dead time beyond that cycle.
- **Simultaneous events:** `en` falling on the stop-sample cycle suppresses that frame's pulse. Reset dominates everything.

## Test plan
- **Good byte:** B=20, send 0xA5 as 8N1 at 20 clocks/bit. Expect exactly one `valid` pulse, `data`=0xA5, `frame_err`=0, and `busy` falling after the pulse.
- **Back-to-back bytes:** B=20, send 0x00, 0xFF, and 0x3C with no idle gap. Expect three `valid` pulses with `data` 0x00, 0xFF, 0x3C in order.
- **Glitch rejection:** B=20, drive `rx` low for 5 clocks, then high. Expect no `valid` or `frame_err`, and `busy` back to 0 at about T0+11.
- **Framing error:** B=20, send 0x55 with the stop bit low, then hold `rx` low for 40 clocks, then high. Expect one `frame_err` pulse, `data`=0x55, no `valid`, and no retrigger until `rx` rises.
- **Abort:** B=20, deassert `en` during bit 3 of 0x81. Expect no pulses and `data` unchanged. Re-enable and send 0x81: `valid` and `data`=0x81.
- **Reset and clamp:**
  - Assert `rstn`=0 mid-frame: all outputs go to 0 and the block returns to IDLE.
  - Then use `baud`=2 with frames sent at 4 clocks/bit: 0x6E is received correctly.
